// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the RV32 instruction fetch unit.
// Contents:
//   NOP_INSTR            - canonical RV32I NOP (addi x0, x0, 0)
//   DEFAULT_RESET_VECTOR - default first fetch address after reset
//   ST_FETCH/ST_SQUASH/ST_HOLD - fetch FSM state encodings
//   align_word()         - clears the two low address bits
package rv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Fetch FSM states.
  //   ST_FETCH  : request outstanding at fetch_pc
  //   ST_SQUASH : redirect arrived during busywait; the in-flight word is dropped
  //   ST_HOLD   : a completed word waits in the hold buffer for STALL to drop
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_SQUASH = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and memory (slave).
// Signals:
//   imem_addr     - word address of the current fetch
//   imem_read     - read request
//   imem_data     - returned instruction word
//   imem_busywait - memory not ready
// Handshake: a read transfer completes on the rising clock edge at which
// imem_read=1 and imem_busywait=0; while imem_busywait=1 the master holds
// imem_addr and imem_read stable, and imem_data is only meaningful on the
// completing edge.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_data;
  logic        imem_busywait;

  modport master (
    output imem_addr,
    output imem_read,
    input  imem_data,
    input  imem_busywait
  );

  modport slave (
    input  imem_addr,
    input  imem_read,
    output imem_data,
    output imem_busywait
  );
endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry skid buffer for a fetched word that completed while the
// downstream IF/ID register was stalled.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_load         - capture i_word/i_pc and mark entry valid
//   i_drain        - entry consumed; mark empty
//   i_clear        - discard entry (redirect); wins over load/drain
//   o_word, o_pc, o_valid - stored entry
module fetch_hold_buffer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc,
  output logic [31:0] o_word,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_word;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word  <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_word  = r_word;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32 instruction fetch unit: issues word reads to instruction memory,
// presents fetched words to the IF/ID register, honours STALL through a
// one-entry hold buffer and redirects on BRANCH_TAKEN.
// Parameter:
//   RESET_VECTOR     - first fetch address after reset
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_stall          - IF/ID cannot accept; presented outputs hold
//   i_branch_taken   - redirect and flush the presented instruction
//   i_branch_target  - redirect address
//   imem             - instruction memory bus (master modport)
//   o_instruction, o_pc, o_pc_plus_4, o_instr_valid - IF/ID payload
//   o_misaligned     - sticky misaligned-redirect trap (FETCH_MISALIGN_TRAP_EN only)
//   o_dbg_state      - current FSM state
// Build option: define FETCH_MISALIGN_TRAP_EN to trap redirects whose target
// has nonzero low bits instead of silently clearing them.
module instruction_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_stall,
  input  logic                       i_branch_taken,
  input  logic [31:0]                i_branch_target,
  instruction_fetch_unit_if.master   imem,
  output logic [31:0]                o_instruction,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_pc_plus_4,
  output logic                       o_instr_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                       o_misaligned,
`endif
  output logic [1:0]                 o_dbg_state
);

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_target;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4;
  logic        r_valid;

  logic        w_trap;
  logic [31:0] w_target;
  logic        w_buf_load;
  logic        w_buf_drain;
  logic        w_buf_clear;
  logic [31:0] w_buf_word;
  logic [31:0] w_buf_pc;
  logic        w_buf_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_trap       = r_misaligned;
  assign o_misaligned = r_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  assign w_target = align_word(i_branch_target);

  // Hold buffer control. A redirect always discards a buffered word.
  assign w_buf_clear = i_branch_taken;
  assign w_buf_load  = !w_trap && !i_branch_taken && (r_state == ST_FETCH) &&
                       !imem.imem_busywait && i_stall;
  assign w_buf_drain = !w_trap && !i_branch_taken && (r_state == ST_HOLD) &&
                       !i_stall && w_buf_valid;

  fetch_hold_buffer u_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (w_buf_clear),
    .i_word  (imem.imem_data),
    .i_pc    (r_fetch_pc),
    .o_word  (w_buf_word),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_FETCH;
      r_fetch_pc  <= RESET_VECTOR;
      r_target    <= 32'h0;
      r_instr     <= NOP_INSTR;
      r_pc        <= 32'h0;
      r_pc_plus_4 <= 32'h0;
      r_valid     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else if (!w_trap) begin
      if (i_branch_taken) begin
        // Redirect beats both STALL and a completing fetch.
        r_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (i_branch_target[1:0] != 2'b00) begin
          r_misaligned <= 1'b1;
          r_state      <= ST_FETCH;
        end else
`endif
        if ((r_state != ST_HOLD) && imem.imem_busywait) begin
          // The bus request cannot be withdrawn mid-busywait: keep the
          // address stable, remember the target, drop the word when it lands.
          r_target <= w_target;
          r_state  <= ST_SQUASH;
        end else begin
          r_fetch_pc <= w_target;
          r_state    <= ST_FETCH;
        end
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (!imem.imem_busywait) begin
              if (!i_stall) begin
                r_instr     <= imem.imem_data;
                r_pc        <= r_fetch_pc;
                r_pc_plus_4 <= r_fetch_pc + 32'd4;
                r_valid     <= 1'b1;
                r_fetch_pc  <= r_fetch_pc + 32'd4;
              end else begin
                r_state <= ST_HOLD;
              end
            end
          end
          ST_SQUASH: begin
            if (!imem.imem_busywait) begin
              r_fetch_pc <= r_target;
              r_state    <= ST_FETCH;
            end
          end
          ST_HOLD: begin
            if (!i_stall) begin
              r_instr     <= w_buf_word;
              r_pc        <= w_buf_pc;
              r_pc_plus_4 <= w_buf_pc + 32'd4;
              r_valid     <= 1'b1;
              r_fetch_pc  <= r_fetch_pc + 32'd4;
              r_state     <= ST_FETCH;
            end
          end
          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

  assign imem.imem_addr = r_fetch_pc;
  assign imem.imem_read = (r_state != ST_HOLD) && !w_trap;

  assign o_instruction = r_instr;
  assign o_pc          = r_pc;
  assign o_pc_plus_4   = r_pc_plus_4;
  assign o_instr_valid = r_valid;
  assign o_dbg_state   = r_state;

endmodule
